// File: rtl/ili934x_bus_decoder.sv
// Display-side receiver for the ILI934x 8080 write bus: decodes commands, CASET/PASET windows and RAMWR pixels.
// Strobes are registered one edge after the sampled wr_n rise; there is no backpressure, every pulse must be consumed.
module ili934x_bus_decoder #(
   parameter int WR_PULSE_CYC = 2,
   parameter int WR_RECOV_CYC = 1,
   parameter int X_RES        = 240,
   parameter int Y_RES        = 320
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lcd_cs_n,
   input  logic        lcd_dc,
   input  logic        lcd_wr_n,
   input  logic        lcd_rd_n,
   input  logic        lcd_rst_n,
   input  logic [7:0]  lcd_d,
   input  logic        err_clr,
   output logic        cmd_stb,
   output logic [7:0]  cmd_code,
   output logic        param_stb,
   output logic [3:0]  param_idx,
   output logic [7:0]  param_data,
   output logic        pix_valid,
   output logic [15:0] pix_x,
   output logic [15:0] pix_y,
   output logic [15:0] pix_data,
   output logic        frame_done,
   output logic [15:0] win_x0,
   output logic [15:0] win_x1,
   output logic [15:0] win_y0,
   output logic [15:0] win_y1,
   output logic        timing_err,
   output logic        win_err,
   output logic        frag_err
);

   typedef enum logic [1:0] {IDLE, CMD_PARAM, PIX_HI, PIX_LO} state_t;

   localparam logic [15:0] XMAX       = 16'(X_RES - 1);
   localparam logic [15:0] YMAX       = 16'(Y_RES - 1);
   localparam logic [7:0]  PULSE_MIN  = 8'(WR_PULSE_CYC);
   localparam logic [7:0]  RECOV_MIN  = 8'(WR_RECOV_CYC);

   logic        cs_n_q, dc_q, wr_n_q, rd_n_q, rst_n_q, wr_n_p_q, cs_n_p_q;
   logic [7:0]  d_q;
   logic [7:0]  lvl_cnt_q, last_len_q;
   logic        recov_short_q, prev_acc_q;

   state_t      state_q, state_d;
   logic [3:0]  pcnt_q, pcnt_d;
   logic [7:0]  pb0_q, pb0_d, pb1_q, pb1_d, pb2_q, pb2_d, hi_q, hi_d;
   logic [15:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [15:0] win_x0_q, win_x0_d, win_x1_q, win_x1_d, win_y0_q, win_y0_d, win_y1_q, win_y1_d;
   logic        cmd_stb_q, cmd_stb_d, param_stb_q, param_stb_d, pix_valid_q, pix_valid_d;
   logic        frame_done_q, frame_done_d;
   logic [7:0]  cmd_code_q, cmd_code_d, param_data_q, param_data_d;
   logic [3:0]  param_idx_q, param_idx_d;
   logic [15:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, pix_data_q, pix_data_d;
   logic        timing_err_q, timing_err_d, win_err_q, win_err_d, frag_err_q, frag_err_d;

   logic        wr_rise, wr_fall, cs_rise, acc, timing_set, win_set, frag_set;
   logic [15:0] s_new, e_new;

   assign wr_rise = wr_n_q & ~wr_n_p_q;
   assign wr_fall = ~wr_n_q & wr_n_p_q;
   assign cs_rise = cs_n_q & ~cs_n_p_q;
   assign acc     = wr_rise & ~cs_n_q & rst_n_q;
   assign s_new   = {pb0_q, pb1_q};
   assign e_new   = {pb2_q, d_q};

   always_comb begin
      state_d      = state_q;
      pcnt_d       = pcnt_q;
      pb0_d        = pb0_q;
      pb1_d        = pb1_q;
      pb2_d        = pb2_q;
      hi_d         = hi_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      win_x0_d     = win_x0_q;
      win_x1_d     = win_x1_q;
      win_y0_d     = win_y0_q;
      win_y1_d     = win_y1_q;
      cmd_code_d   = cmd_code_q;
      param_idx_d  = param_idx_q;
      param_data_d = param_data_q;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_data_d   = pix_data_q;
      cmd_stb_d    = 1'b0;
      param_stb_d  = 1'b0;
      pix_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      win_set      = 1'b0;
      frag_set     = 1'b0;
      timing_set   = (acc && ((last_len_q < PULSE_MIN) || recov_short_q))
                   || (!rd_n_q && !wr_n_q && !cs_n_q);

      if (!rst_n_q) begin
         state_d  = IDLE;
         pcnt_d   = 4'd0;
         cur_x_d  = 16'd0;
         cur_y_d  = 16'd0;
         win_x0_d = 16'd0;
         win_x1_d = XMAX;
         win_y0_d = 16'd0;
         win_y1_d = YMAX;
      end else if (acc && !dc_q) begin
         cmd_stb_d  = 1'b1;
         cmd_code_d = d_q;
         pcnt_d     = 4'd0;
         if (d_q == 8'h2C) begin
            cur_x_d = win_x0_q;
            cur_y_d = win_y0_q;
            state_d = PIX_HI;
         end else if (d_q == 8'h3C) begin
            state_d = PIX_HI;
         end else begin
            state_d = CMD_PARAM;
         end
      end else if (acc) begin
         case (state_q)
            PIX_HI: begin
               hi_d    = d_q;
               state_d = PIX_LO;
            end
            PIX_LO: begin
               pix_valid_d = 1'b1;
               pix_x_d     = cur_x_q;
               pix_y_d     = cur_y_q;
               pix_data_d  = {hi_q, d_q};
               state_d     = PIX_HI;
               if (cur_x_q == win_x1_q) begin
                  cur_x_d = win_x0_q;
                  if (cur_y_q == win_y1_q) begin
                     cur_y_d      = win_y0_q;
                     frame_done_d = 1'b1;
                  end else begin
                     cur_y_d = cur_y_q + 16'd1;
                  end
               end else begin
                  cur_x_d = cur_x_q + 16'd1;
               end
            end
            default: begin
               param_stb_d  = 1'b1;
               param_idx_d  = pcnt_q;
               param_data_d = d_q;
               if (pcnt_q != 4'd15) pcnt_d = pcnt_q + 4'd1;
               if (state_q == CMD_PARAM) begin
                  case (pcnt_q)
                     4'd0: pb0_d = d_q;
                     4'd1: pb1_d = d_q;
                     4'd2: pb2_d = d_q;
                     4'd3: begin
                        // Cursor follows a committed window so it can never sit outside it.
                        if (cmd_code_q == 8'h2A) begin
                           if (s_new <= e_new && e_new <= XMAX) begin
                              win_x0_d = s_new;
                              win_x1_d = e_new;
                              cur_x_d  = s_new;
                           end else begin
                              win_set = 1'b1;
                           end
                        end else if (cmd_code_q == 8'h2B) begin
                           if (s_new <= e_new && e_new <= YMAX) begin
                              win_y0_d = s_new;
                              win_y1_d = e_new;
                              cur_y_d  = s_new;
                           end else begin
                              win_set = 1'b1;
                           end
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end else if (cs_rise && state_q == PIX_LO) begin
         frag_set = 1'b1;
         state_d  = PIX_HI;
      end

      timing_err_d = (timing_err_q & ~err_clr) | timing_set;
      win_err_d    = (win_err_q & ~err_clr) | win_set;
      frag_err_d   = (frag_err_q & ~err_clr) | frag_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_n_q <= 1'b1; dc_q <= 1'b0; wr_n_q <= 1'b1; rd_n_q <= 1'b1; rst_n_q <= 1'b1;
         wr_n_p_q <= 1'b1; cs_n_p_q <= 1'b1; d_q <= 8'd0;
         lvl_cnt_q <= 8'hFF; last_len_q <= 8'hFF; recov_short_q <= 1'b0; prev_acc_q <= 1'b0;
         state_q <= IDLE; pcnt_q <= 4'd0; pb0_q <= 8'd0; pb1_q <= 8'd0; pb2_q <= 8'd0; hi_q <= 8'd0;
         cur_x_q <= 16'd0; cur_y_q <= 16'd0;
         win_x0_q <= 16'd0; win_x1_q <= XMAX; win_y0_q <= 16'd0; win_y1_q <= YMAX;
         cmd_stb_q <= 1'b0; param_stb_q <= 1'b0; pix_valid_q <= 1'b0; frame_done_q <= 1'b0;
         cmd_code_q <= 8'd0; param_idx_q <= 4'd0; param_data_q <= 8'd0;
         pix_x_q <= 16'd0; pix_y_q <= 16'd0; pix_data_q <= 16'd0;
         timing_err_q <= 1'b0; win_err_q <= 1'b0; frag_err_q <= 1'b0;
      end else begin
         cs_n_q <= lcd_cs_n; dc_q <= lcd_dc; wr_n_q <= lcd_wr_n; rd_n_q <= lcd_rd_n;
         rst_n_q <= lcd_rst_n; d_q <= lcd_d; wr_n_p_q <= wr_n_q; cs_n_p_q <= cs_n_q;
         // lvl_cnt_q is the run length of the current wr_n level; last_len_q the run that just ended.
         if (lcd_wr_n != wr_n_q) begin
            lvl_cnt_q  <= 8'd1;
            last_len_q <= lvl_cnt_q;
         end else if (lvl_cnt_q != 8'hFF) begin
            lvl_cnt_q <= lvl_cnt_q + 8'd1;
         end
         if (wr_fall) recov_short_q <= prev_acc_q && (last_len_q < RECOV_MIN);
         if (acc) prev_acc_q <= 1'b1;
         state_q <= state_d; pcnt_q <= pcnt_d; pb0_q <= pb0_d; pb1_q <= pb1_d; pb2_q <= pb2_d;
         hi_q <= hi_d; cur_x_q <= cur_x_d; cur_y_q <= cur_y_d;
         win_x0_q <= win_x0_d; win_x1_q <= win_x1_d; win_y0_q <= win_y0_d; win_y1_q <= win_y1_d;
         cmd_stb_q <= cmd_stb_d; param_stb_q <= param_stb_d; pix_valid_q <= pix_valid_d;
         frame_done_q <= frame_done_d; cmd_code_q <= cmd_code_d; param_idx_q <= param_idx_d;
         param_data_q <= param_data_d; pix_x_q <= pix_x_d; pix_y_q <= pix_y_d; pix_data_q <= pix_data_d;
         timing_err_q <= timing_err_d; win_err_q <= win_err_d; frag_err_q <= frag_err_d;
      end
   end

   assign cmd_stb    = cmd_stb_q;
   assign cmd_code   = cmd_code_q;
   assign param_stb  = param_stb_q;
   assign param_idx  = param_idx_q;
   assign param_data = param_data_q;
   assign pix_valid  = pix_valid_q;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign pix_data   = pix_data_q;
   assign frame_done = frame_done_q;
   assign win_x0     = win_x0_q;
   assign win_x1     = win_x1_q;
   assign win_y0     = win_y0_q;
   assign win_y1     = win_y1_q;
   assign timing_err = timing_err_q;
   assign win_err    = win_err_q;
   assign frag_err   = frag_err_q;

endmodule
